// File: rtl/out_channel_checker.sv
// Out-channel checker: queues words from a producer in a small FIFO and compares
// each popped word against a preloaded expected-value table.
module out_channel_checker #(
    parameter int MemoryElementWidth = 12,
    parameter int NExpected          = 8,
    parameter int Depth              = 4,
    localparam int AW = $clog2(NExpected),
    localparam int CW = $clog2(NExpected) + 1,
    localparam int PW = $clog2(Depth)
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          exp_we,
    input  logic [AW-1:0]                 exp_addr,
    input  logic [MemoryElementWidth-1:0] exp_data,
    input  logic [CW-1:0]                 exp_count,
    input  logic                          start,
    input  logic                          out_valid,
    input  logic [MemoryElementWidth-1:0] out_data,
    output logic                          out_ready,
    input  logic                          drain_en,
    input  logic                          prog_done,
    output logic                          finished,
    output logic                          success,
    output logic [CW-1:0]                 checked,
    output logic [CW-1:0]                 mismatch_index
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    localparam logic [CW-1:0] NEXP_C = CW'(NExpected);
    localparam logic [PW:0]   FULL_C = (PW+1)'(Depth);

    state_t                        r_state;
    logic [MemoryElementWidth-1:0] r_table [NExpected];
    logic [MemoryElementWidth-1:0] r_fifo  [Depth];
    logic [PW-1:0]                 r_wptr;
    logic [PW-1:0]                 r_rptr;
    logic [PW:0]                   r_count;
    logic [CW-1:0]                 r_exp_count;
    logic [CW-1:0]                 r_checked;
    logic [CW-1:0]                 r_mismatch_index;
    logic                          r_error;
    logic                          r_finished;
    logic                          r_success;

    logic                          w_idle_like;
    logic                          w_ready;
    logic                          w_push;
    logic                          w_pop;
    logic                          w_in_range;
    logic [MemoryElementWidth-1:0] w_head;
    logic [MemoryElementWidth-1:0] w_expected;
    logic                          w_bad;

    assign w_idle_like = (r_state == S_IDLE) || (r_state == S_DONE);
    assign w_ready     = (r_state == S_RUN) && (r_count != FULL_C);
    assign w_push      = out_valid && w_ready;
    assign w_pop       = ((r_state == S_RUN) || (r_state == S_DRAIN)) && (r_count != '0) && drain_en;
    assign w_in_range  = r_checked < NEXP_C;
    assign w_head      = r_fifo[r_rptr];
    // Low index bits wrap once checked saturates; w_in_range flags that case as an error.
    assign w_expected  = r_table[r_checked[AW-1:0]];
    assign w_bad       = !w_in_range || (r_checked >= r_exp_count) || (w_head != w_expected);

    always_ff @(posedge clock) begin
        if (!reset && w_idle_like && exp_we)
            r_table[exp_addr] <= exp_data;
    end

    always_ff @(posedge clock) begin
        if (w_push)
            r_fifo[r_wptr] <= out_data;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state          <= S_IDLE;
            r_wptr           <= '0;
            r_rptr           <= '0;
            r_count          <= '0;
            r_exp_count      <= '0;
            r_checked        <= '0;
            r_mismatch_index <= '1;
            r_error          <= 1'b0;
            r_finished       <= 1'b0;
            r_success        <= 1'b0;
        end else begin
            if (w_push)
                r_wptr <= r_wptr + 1'b1;
            if (w_pop)
                r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase

            if (w_pop) begin
                if (w_in_range)
                    r_checked <= r_checked + 1'b1;
                if (w_bad && !r_error) begin
                    r_error          <= 1'b1;
                    r_mismatch_index <= r_checked;
                end
            end

            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_state          <= S_RUN;
                        r_exp_count      <= exp_count;
                        r_checked        <= '0;
                        r_wptr           <= '0;
                        r_rptr           <= '0;
                        r_count          <= '0;
                        r_error          <= 1'b0;
                        r_finished       <= 1'b0;
                        r_success        <= 1'b0;
                        r_mismatch_index <= '1;
                    end
                end
                S_RUN: begin
                    if (prog_done)
                        r_state <= S_DRAIN;
                end
                S_DRAIN: begin
                    // Nothing can be pushed in DRAIN, so an empty FIFO means every word is judged.
                    if (r_count == '0) begin
                        r_state    <= S_DONE;
                        r_finished <= 1'b1;
                        r_success  <= !r_error && (r_checked == r_exp_count);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign out_ready      = w_ready;
    assign finished       = r_finished;
    assign success        = r_success;
    assign checked        = r_checked;
    assign mismatch_index = r_mismatch_index;

endmodule

// File: tb/tb_out_channel_checker.sv
// Directed bench for out_channel_checker: a queue-based reference model is checked
// against the DUT every cycle, plus literal expectations at scenario boundaries.
module tb_out_channel_checker;

    localparam int W    = 12;
    localparam int NEXP = 8;
    localparam int DEP  = 4;
    localparam int AW   = $clog2(NEXP);
    localparam int CW   = $clog2(NEXP) + 1;
    localparam int NONE = (1 << CW) - 1;

    logic          clock;
    logic          reset;
    logic          exp_we;
    logic [AW-1:0] exp_addr;
    logic [W-1:0]  exp_data;
    logic [CW-1:0] exp_count;
    logic          start;
    logic          out_valid;
    logic [W-1:0]  out_data;
    logic          out_ready;
    logic          drain_en;
    logic          prog_done;
    logic          finished;
    logic          success;
    logic [CW-1:0] checked;
    logic [CW-1:0] mismatch_index;

    out_channel_checker #(.MemoryElementWidth(W), .NExpected(NEXP), .Depth(DEP)) dut (
        .clock(clock), .reset(reset), .exp_we(exp_we), .exp_addr(exp_addr),
        .exp_data(exp_data), .exp_count(exp_count), .start(start),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .drain_en(drain_en), .prog_done(prog_done), .finished(finished),
        .success(success), .checked(checked), .mismatch_index(mismatch_index)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference model: 0 idle, 1 run, 2 drain, 3 done
    int          m_phase = 0;
    logic [W-1:0] m_q[$];
    logic [W-1:0] m_tbl[NEXP];
    int          m_cnt = 0, m_checked = 0, m_mi = NONE;
    bit          m_err = 0, m_fin = 0, m_succ = 0;

    always @(posedge clock) begin
        if (reset) begin
            m_phase = 0; m_q.delete(); m_checked = 0; m_mi = NONE;
            m_err = 0; m_fin = 0; m_succ = 0;
        end else begin
            int  size0;
            bit  do_push, do_pop, bad;
            logic [W-1:0] w;
            size0   = m_q.size();
            do_push = out_valid && m_phase == 1 && size0 < DEP;
            do_pop  = (m_phase == 1 || m_phase == 2) && size0 > 0 && drain_en;
            if (m_phase == 0 || m_phase == 3) begin
                if (exp_we) m_tbl[exp_addr] = exp_data;
                if (start) begin
                    m_phase = 1; m_cnt = exp_count; m_q.delete(); m_checked = 0;
                    m_err = 0; m_fin = 0; m_succ = 0; m_mi = NONE;
                end
            end else begin
                if (do_pop) begin
                    w   = m_q.pop_front();
                    bad = m_checked >= m_cnt || m_checked >= NEXP;
                    if (!bad && w != m_tbl[m_checked]) bad = 1;
                    if (bad && !m_err) begin m_err = 1; m_mi = m_checked; end
                    if (m_checked < NEXP) m_checked++;
                end
                if (do_push) m_q.push_back(out_data);
                if (m_phase == 1 && prog_done) m_phase = 2;
                else if (m_phase == 2 && size0 == 0) begin
                    m_phase = 3; m_fin = 1; m_succ = !m_err && m_checked == m_cnt;
                end
            end
        end
    end

    int n_total = 0, n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_total++;
        if (act !== expv)
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
        else
            n_pass++;
    endtask

    task automatic compare_all();
        chk("out_ready", 32'(out_ready), 32'(m_phase == 1 && m_q.size() < DEP));
        chk("finished", 32'(finished), 32'(m_fin));
        chk("success", 32'(success), 32'(m_succ));
        chk("checked", 32'(checked), 32'(m_checked));
        chk("mismatch_index", 32'(mismatch_index), 32'(m_mi));
    endtask

    task automatic cyc();
        @(posedge clock);
        @(negedge clock);
        compare_all();
    endtask

    task automatic wr(input int a, input int d);
        exp_we = 1; exp_addr = AW'(a); exp_data = W'(d);
        cyc();
        exp_we = 0;
    endtask

    task automatic go(input int cnt);
        exp_count = CW'(cnt); start = 1;
        cyc();
        start = 0;
    endtask

    task automatic push(input int d);
        out_valid = 1; out_data = W'(d);
        cyc();
        out_valid = 0;
    endtask

    task automatic finish_prog();
        prog_done = 1;
        cyc();
        prog_done = 0;
        for (int i = 0; i < 20 && !finished; i++) cyc();
        chk("done_reached", 32'(finished), 32'd1);
    endtask

    initial begin
        reset = 1; exp_we = 0; exp_addr = 0; exp_data = 0; exp_count = 0;
        start = 0; out_valid = 0; out_data = 0; drain_en = 0; prog_done = 0;
        cyc(); cyc();
        chk("rst_finished", 32'(finished), 32'd0);
        chk("rst_success", 32'(success), 32'd0);
        chk("rst_ready", 32'(out_ready), 32'd0);
        chk("rst_checked", 32'(checked), 32'd0);
        chk("rst_mi", 32'(mismatch_index), NONE);
        reset = 0;
        cyc();

        // single matching word
        wr(0, 2); go(1); drain_en = 1; push(2); finish_prog();
        chk("t1_success", 32'(success), 32'd1);
        chk("t1_checked", 32'(checked), 32'd1);
        chk("t1_mi", 32'(mismatch_index), NONE);

        // single mismatching word, restarted from DONE
        go(1); push(3); finish_prog();
        chk("t2_success", 32'(success), 32'd0);
        chk("t2_mi", 32'(mismatch_index), 32'd0);

        // fill FIFO with drain held off; start/exp_we in RUN must be ignored
        wr(0, 10); wr(1, 11); wr(2, 12); wr(3, 13);
        go(4); drain_en = 0;
        push(10);
        start = 1; exp_we = 1; exp_addr = 0; exp_data = 0; exp_count = 1;
        push(11);
        start = 0; exp_we = 0;
        push(12); push(13);
        chk("t3_full_ready", 32'(out_ready), 32'd0);
        push(99);
        drain_en = 1; cyc();
        chk("t3_ready_back", 32'(out_ready), 32'd1);
        chk("t3_checked1", 32'(checked), 32'd1);
        cyc(); cyc(); cyc();
        chk("t3_checked4", 32'(checked), 32'd4);
        finish_prog();
        chk("t3_success", 32'(success), 32'd1);

        // back-to-back push with simultaneous pop
        go(3); push(10); push(11); push(12); finish_prog();
        chk("t4_success", 32'(success), 32'd1);
        chk("t4_checked", 32'(checked), 32'd3);

        // too few words
        go(2); push(10); finish_prog();
        chk("t5_success", 32'(success), 32'd0);
        chk("t5_checked", 32'(checked), 32'd1);
        chk("t5_mi", 32'(mismatch_index), NONE);

        // too many words
        wr(0, 2); go(1); push(2); push(5); finish_prog();
        chk("t6_success", 32'(success), 32'd0);
        chk("t6_mi", 32'(mismatch_index), 32'd1);

        // saturation of checked at NExpected
        for (int i = 0; i < NEXP; i++) wr(i, i * 3 + 1);
        go(NEXP);
        for (int i = 0; i < NEXP; i++) push(i * 3 + 1);
        push(7); finish_prog();
        chk("t7_checked", 32'(checked), 32'(NEXP));
        chk("t7_mi", 32'(mismatch_index), 32'(NEXP));
        chk("t7_success", 32'(success), 32'd0);

        // reset mid-run discards queued words
        go(4); drain_en = 0; push(1); push(2);
        reset = 1; cyc();
        chk("t8_finished", 32'(finished), 32'd0);
        chk("t8_ready", 32'(out_ready), 32'd0);
        chk("t8_checked", 32'(checked), 32'd0);
        chk("t8_mi", 32'(mismatch_index), NONE);
        reset = 0; cyc();
        wr(0, 2); go(1); drain_en = 1; push(2); finish_prog();
        chk("t8_success", 32'(success), 32'd1);
        chk("t8_checked1", 32'(checked), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/out_channel_checker.md
OUT_CHANNEL_CHECKER -- requirements
Module: out_channel_checker

Interface
REQ-001 SHALL have parameter MemoryElementWidth, default 12, width of one out-channel word.
REQ-002 SHALL have parameter NExpected, default 8, number of entries in the expected-value table.
REQ-003 SHALL have parameter Depth, default 4, FIFO depth in words (power of two, >= 2).
REQ-004 SHALL have one clock; reset is synchronous and active-high; ports named clock and reset.
REQ-005 Ports: clock  in  1  clock.
REQ-006 reset  in  1  synchronous active-high reset.
REQ-007 exp_we  in  1  write expected table entry this cycle.
REQ-008 exp_addr  in  clog2(NExpected)  expected table index.
REQ-009 exp_data  in  MemoryElementWidth  expected value.
REQ-010 exp_count  in  clog2(NExpected)+1  number of words the program must emit; sampled on start.
REQ-011 start  in  1  begin a check run.
REQ-012 out_valid  in  1  producer presents an out-channel word.
REQ-013 out_data  in  MemoryElementWidth  out-channel word.
REQ-014 out_ready  out  1  checker accepts word (FIFO not full and state RUN).
REQ-015 drain_en  in  1  checker permitted to pop FIFO this cycle.
REQ-016 prog_done  in  1  producer has finished; no further words.
REQ-017 finished  out  1  check complete.
REQ-018 success  out  1  all words matched and count correct; valid when finished=1.
REQ-019 checked  out  clog2(NExpected)+1  words compared so far.
REQ-020 mismatch_index  out  clog2(NExpected)+1  index of first failing word; all-ones if none.

Function
REQ-021 States: IDLE, RUN, DRAIN, DONE; reset enters IDLE.
REQ-022 IDLE: exp_we writes table[exp_addr]=exp_data; start -> RUN, latch exp_count, clear checked, FIFO and error flag.
REQ-023 Push: out_valid && out_ready writes out_data into FIFO same edge.
REQ-024 out_ready SHALL be 0 in IDLE, DRAIN, DONE and when FIFO holds Depth words.
REQ-025 Pop: FIFO non-empty && drain_en in RUN or DRAIN; head compared to table[checked]; checked increments same edge.
REQ-026 Minimum latency: word pushed at edge N is compared at edge N+1.
REQ-027 Simultaneous push and pop SHALL both occur; occupancy unchanged.
REQ-028 Mismatch, or pop with checked >= latched exp_count, sets error flag; first occurrence records checked into mismatch_index.
REQ-029 checked SHALL saturate at NExpected; pops beyond it still count as errors.
REQ-030 RUN: prog_done -> DRAIN (push of same cycle still accepted).
REQ-031 DRAIN: FIFO empty -> DONE; finished=1; success = !error && checked == latched exp_count.
REQ-032 DONE: outputs held until reset or start; start in DONE behaves as in IDLE.
REQ-033 start outside IDLE/DONE SHALL be ignored.
REQ-034 exp_we outside IDLE/DONE SHALL be ignored.

Reset
REQ-035 On reset: state IDLE, FIFO empty, finished=0, success=0, out_ready=0, checked=0, mismatch_index=all-ones, error cleared.
REQ-036 Reset mid-run SHALL discard FIFO contents and in-progress results; expected table contents unspecified after reset.

Verification
REQ-037 table[0]=2, exp_count=1, start, push 2, drain_en=1, prog_done -> finished=1, success=1, checked=1.
REQ-038 Same setup, push 3 -> finished=1, success=0, mismatch_index=0.
REQ-039 drain_en=0, push 4 words (Depth=4) -> out_ready=0 after 4th; drain_en=1 -> all 4 compared in order, out_ready returns 1.
REQ-040 exp_count=2, push one matching word, prog_done -> success=0, checked=1, mismatch_index=all-ones.
REQ-041 exp_count=1, push 2 then 5 -> success=0, mismatch_index=1.
REQ-042 Reset asserted in RUN with 2 words queued -> next cycle state IDLE, finished=0, out_ready=0, checked=0.
